queue_credit_monitor: RTL and testbench

QUEUE_CREDIT_MONITOR -- requirements
Module: queue_credit_monitor

---
 rtl/queue_credit_monitor.sv | 159 +++++++++++++++
 tb/tb_queue_credit_monitor.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/queue_credit_monitor.sv
// Passive CQ snooper that shadows QDMA C2H PIDX / CMPT CIDX register writes and
// tracks per-queue descriptor credits and completion-ring space.

module qcm_queue #(
  parameter int RING_SZ = 1024,
  parameter int IDX_W   = 16
) (
  input  logic             user_clk_ip,
  input  logic             user_resetn_ip,
  input  logic             wr_pidx,
  input  logic             wr_cidx,
  input  logic [15:0]      wr_val,
  input  logic             cons_hs,
  input  logic [IDX_W-1:0] cons_cnt,
  input  logic             push_hs,
  output logic [IDX_W-1:0] avail,
  output logic [IDX_W-1:0] space,
  output logic             err
);
  localparam logic [IDX_W-1:0] MASK = IDX_W'(RING_SZ - 1);

  logic [IDX_W-1:0] c2h_pidx, c2h_cidx, cmpt_pidx, cmpt_cidx;
  logic [IDX_W-1:0] val, pidx_n, cidx_n, cpidx_n, ccidx_n, avail_wr;

  always_comb begin
    val      = IDX_W'(wr_val) & MASK;
    pidx_n   = wr_pidx ? val : c2h_pidx;
    cidx_n   = cons_hs ? ((c2h_cidx + cons_cnt) & MASK) : c2h_cidx;
    cpidx_n  = push_hs ? ((cmpt_pidx + IDX_W'(1)) & MASK) : cmpt_pidx;
    ccidx_n  = wr_cidx ? val : cmpt_cidx;
    // overrun test is against the cidx seen before any same-cycle consume
    avail_wr = (val - c2h_cidx) & MASK;
  end

  // outputs are registered from next-state so a write lands in the same edge as the state
  always_ff @(posedge user_clk_ip or negedge user_resetn_ip) begin
    if (!user_resetn_ip) begin
      c2h_pidx  <= '0;
      c2h_cidx  <= '0;
      cmpt_pidx <= '0;
      cmpt_cidx <= '0;
      avail     <= '0;
      space     <= MASK;
      err       <= 1'b0;
    end else begin
      c2h_pidx  <= pidx_n;
      c2h_cidx  <= cidx_n;
      cmpt_pidx <= cpidx_n;
      cmpt_cidx <= ccidx_n;
      avail     <= (pidx_n - cidx_n) & MASK;
      space     <= MASK - ((cpidx_n - ccidx_n) & MASK);
      if (wr_pidx && (avail_wr < avail)) err <= 1'b1;
    end
  end
endmodule

module queue_credit_monitor #(
  parameter int          NUM_Q          = 4,
  parameter int          RING_SZ        = 1024,
  parameter int          IDX_W          = 16,
  parameter logic [19:0] BASE_C2H_PIDX  = 20'h18008,
  parameter logic [19:0] BASE_CMPT_CIDX = 20'h1800C,
  parameter logic [19:0] Q_STRIDE       = 20'h10,
  localparam int         QW             = (NUM_Q > 1) ? $clog2(NUM_Q) : 1
) (
  input  logic                   user_clk_ip,
  input  logic                   user_resetn_ip,
  input  logic [511:0]           m_axis_cq_monitor_tdata,
  input  logic [15:0]            m_axis_cq_monitor_tkeep,
  input  logic [228:0]           m_axis_cq_monitor_tuser,
  input  logic                   m_axis_cq_monitor_tlast,
  input  logic                   m_axis_cq_monitor_tvalid,
  input  logic                   m_axis_cq_monitor_tready,
  input  logic                   cons_valid,
  output logic                   cons_ready,
  input  logic [QW-1:0]          cons_qid,
  input  logic [IDX_W-1:0]       cons_cnt,
  input  logic                   cmpt_valid,
  output logic                   cmpt_ready,
  input  logic [QW-1:0]          cmpt_qid,
  output logic [NUM_Q*IDX_W-1:0] avail_desc_o,
  output logic [NUM_Q*IDX_W-1:0] cmpt_space_o,
  output logic [NUM_Q-1:0]       err_o
);
  logic [NUM_Q-1:0][IDX_W-1:0] avail_arr, space_arr;
  logic [NUM_Q-1:0]            m_pidx, m_cidx, wr_pidx_v, wr_cidx_v, cons_hs_v, push_hs_v;
  logic                        hs, sop, dec, hit_p, hit_c;
  logic [QW-1:0]               dec_qid;
  logic                        s1_hit_p, s1_hit_c;
  logic [QW-1:0]               s1_qid;
  logic [15:0]                 s1_val;
  logic                        unused_bits;

  assign unused_bits = ^{m_axis_cq_monitor_tkeep, m_axis_cq_monitor_tuser,
                         m_axis_cq_monitor_tdata[511:144], m_axis_cq_monitor_tdata[127:79],
                         m_axis_cq_monitor_tdata[63:20], m_axis_cq_monitor_tdata[1:0]};

  assign hs  = m_axis_cq_monitor_tvalid && m_axis_cq_monitor_tready;
  assign dec = hs && sop && (m_axis_cq_monitor_tdata[78:75] == 4'b0001) &&
               (m_axis_cq_monitor_tdata[74:64] != 11'd0);

  always_comb begin
    hit_p   = 1'b0;
    hit_c   = 1'b0;
    dec_qid = '0;
    for (int q = 0; q < NUM_Q; q++)
      if (m_cidx[q]) begin hit_c = 1'b1; dec_qid = QW'(q); end
    for (int q = 0; q < NUM_Q; q++)
      if (m_pidx[q]) begin hit_p = 1'b1; dec_qid = QW'(q); end
  end

  always_ff @(posedge user_clk_ip or negedge user_resetn_ip) begin
    if (!user_resetn_ip) begin
      sop      <= 1'b1;
      s1_hit_p <= 1'b0;
      s1_hit_c <= 1'b0;
      s1_qid   <= '0;
      s1_val   <= '0;
    end else begin
      if (hs) sop <= m_axis_cq_monitor_tlast;
      s1_hit_p <= dec && hit_p;
      s1_hit_c <= dec && hit_c && !hit_p;
      s1_qid   <= dec_qid;
      s1_val   <= m_axis_cq_monitor_tdata[143:128];
    end
  end

  assign cons_ready = cons_valid && (cons_cnt <= avail_arr[cons_qid]);
  assign cmpt_ready = cmpt_valid && (space_arr[cmpt_qid] != '0);

  for (genvar q = 0; q < NUM_Q; q++) begin : g_q
    localparam logic [19:0] PIDX_A = BASE_C2H_PIDX + 20'(q) * Q_STRIDE;
    localparam logic [19:0] CIDX_A = BASE_CMPT_CIDX + 20'(q) * Q_STRIDE;

    assign m_pidx[q]    = (m_axis_cq_monitor_tdata[19:2] == PIDX_A[19:2]);
    assign m_cidx[q]    = (m_axis_cq_monitor_tdata[19:2] == CIDX_A[19:2]);
    assign wr_pidx_v[q] = s1_hit_p && (s1_qid == QW'(q));
    assign wr_cidx_v[q] = s1_hit_c && (s1_qid == QW'(q));
    assign cons_hs_v[q] = cons_ready && (cons_qid == QW'(q));
    assign push_hs_v[q] = cmpt_ready && (cmpt_qid == QW'(q));

    qcm_queue #(.RING_SZ(RING_SZ), .IDX_W(IDX_W)) u_q (
      .user_clk_ip    (user_clk_ip),
      .user_resetn_ip (user_resetn_ip),
      .wr_pidx        (wr_pidx_v[q]),
      .wr_cidx        (wr_cidx_v[q]),
      .wr_val         (s1_val),
      .cons_hs        (cons_hs_v[q]),
      .cons_cnt       (cons_cnt),
      .push_hs        (push_hs_v[q]),
      .avail          (avail_arr[q]),
      .space          (space_arr[q]),
      .err            (err_o[q])
    );
  end

  assign avail_desc_o = avail_arr;
  assign cmpt_space_o = space_arr;
endmodule

// File: tb/tb_queue_credit_monitor.sv
// Directed + random bench for queue_credit_monitor, checked against a ring-index
// model of the per-queue producer/consumer counters.

module tb_queue_credit_monitor;
  localparam int RS = 1024;

  logic         user_clk_ip = 1'b0;
  logic         user_resetn_ip = 1'b0;
  logic [511:0] tdata;
  logic [15:0]  tkeep;
  logic [228:0] tuser;
  logic         tlast, tvalid, tready;
  logic         cons_valid, cons_ready, cmpt_valid, cmpt_ready;
  logic [1:0]   cons_qid, cmpt_qid;
  logic [15:0]  cons_cnt;
  logic [63:0]  avail_desc_o, cmpt_space_o;
  logic [3:0]   err_o;

  int total = 0, bad = 0;
  int mp[4], mc[4], mcp[4], mcc[4];
  bit merr[4];
  bit msop;
  int pend_k, pend_q, pend_v;
  logic [3:0]  b_typ;
  logic [10:0] b_dw;
  logic [19:0] b_addr;
  logic [15:0] b_val;

  queue_credit_monitor #(.NUM_Q(4), .RING_SZ(RS), .IDX_W(16)) dut (
    .user_clk_ip              (user_clk_ip),
    .user_resetn_ip           (user_resetn_ip),
    .m_axis_cq_monitor_tdata  (tdata),
    .m_axis_cq_monitor_tkeep  (tkeep),
    .m_axis_cq_monitor_tuser  (tuser),
    .m_axis_cq_monitor_tlast  (tlast),
    .m_axis_cq_monitor_tvalid (tvalid),
    .m_axis_cq_monitor_tready (tready),
    .cons_valid               (cons_valid),
    .cons_ready               (cons_ready),
    .cons_qid                 (cons_qid),
    .cons_cnt                 (cons_cnt),
    .cmpt_valid               (cmpt_valid),
    .cmpt_ready               (cmpt_ready),
    .cmpt_qid                 (cmpt_qid),
    .avail_desc_o             (avail_desc_o),
    .cmpt_space_o             (cmpt_space_o),
    .err_o                    (err_o)
  );

  always #5 user_clk_ip = ~user_clk_ip;

  function automatic int m_avail(int q);
    return (mp[q] - mc[q] + RS) % RS;
  endfunction

  function automatic int m_space(int q);
    return RS - 1 - ((mcp[q] - mcc[q] + RS) % RS);
  endfunction

  function automatic logic [19:0] reg_addr(int kind, int q);
    return 20'((kind == 0 ? 32'h18008 : 32'h1800C) + 32'(q) * 32'h10);
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int q = 0; q < 4; q++) begin
      mp[q] = 0; mc[q] = 0; mcp[q] = 0; mcc[q] = 0; merr[q] = 1'b0;
    end
    msop = 1'b1;
    pend_k = 0; pend_q = 0; pend_v = 0;
  endtask

  task automatic idle_in();
    tvalid = 1'b0; tready = 1'b0; tlast = 1'b0;
    cons_valid = 1'b0; cons_qid = '0; cons_cnt = '0;
    cmpt_valid = 1'b0; cmpt_qid = '0;
  endtask

  task automatic set_beat(bit v, bit rdy, bit last, logic [3:0] typ, logic [10:0] dw,
                          logic [19:0] addr, logic [15:0] val);
    b_typ = typ; b_dw = dw; b_addr = addr; b_val = val;
    for (int i = 0; i < 16; i++) tdata[i*32 +: 32] = $urandom;
    tdata[78:75]   = typ;
    tdata[74:64]   = dw;
    tdata[19:0]    = addr;
    tdata[143:128] = val;
    tkeep  = 16'($urandom);
    tuser  = 229'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    tvalid = v; tready = rdy; tlast = last;
  endtask

  // one clock: check readies, advance the model at the edge, check outputs at the next negedge
  task automatic tick();
    bit ecr, emr;
    logic [63:0] ea, es;
    logic [3:0] ee;
    #1;
    ecr = cons_valid && (int'(cons_cnt) <= m_avail(int'(cons_qid)));
    emr = cmpt_valid && (m_space(int'(cmpt_qid)) != 0);
    chk("cons_ready", 64'(cons_ready), 64'(ecr));
    chk("cmpt_ready", 64'(cmpt_ready), 64'(emr));
    @(posedge user_clk_ip);
    if (pend_k == 1) begin
      if ((pend_v - mc[pend_q] + RS) % RS < m_avail(pend_q)) merr[pend_q] = 1'b1;
      mp[pend_q] = pend_v;
    end else if (pend_k == 2) begin
      mcc[pend_q] = pend_v;
    end
    if (ecr) mc[cons_qid] = (mc[cons_qid] + int'(cons_cnt)) % RS;
    if (emr) mcp[cmpt_qid] = (mcp[cmpt_qid] + 1) % RS;
    pend_k = 0;
    if (tvalid && tready) begin
      if (msop && b_typ == 4'b0001 && b_dw != 0) begin
        for (int q = 0; q < 4; q++) begin
          if ((int'(b_addr) >> 2) == ((32'h18008 + q * 16) >> 2)) begin
            pend_k = 1; pend_q = q; pend_v = int'(b_val) % RS;
          end else if ((int'(b_addr) >> 2) == ((32'h1800C + q * 16) >> 2)) begin
            pend_k = 2; pend_q = q; pend_v = int'(b_val) % RS;
          end
        end
      end
      msop = tlast;
    end
    @(negedge user_clk_ip);
    for (int q = 0; q < 4; q++) begin
      ea[q*16 +: 16] = 16'(m_avail(q));
      es[q*16 +: 16] = 16'(m_space(q));
      ee[q]          = merr[q];
    end
    chk("avail_desc_o", avail_desc_o, ea);
    chk("cmpt_space_o", cmpt_space_o, es);
    chk("err_o", 64'(err_o), 64'(ee));
  endtask

  initial begin
    int q, kind;
    idle_in();
    set_beat(1'b0, 1'b0, 1'b0, 4'h0, 11'd0, 20'h0, 16'h0);
    model_reset();
    repeat (2) @(negedge user_clk_ip);
    chk("rst_avail", avail_desc_o, 64'h0);
    chk("rst_space", cmpt_space_o, 64'h03FF_03FF_03FF_03FF);
    chk("rst_err", 64'(err_o), 64'h0);
    user_resetn_ip = 1'b1;
    tick(); tick();

    // PIDX write to q2, visible two cycles after the beat
    set_beat(1'b1, 1'b1, 1'b1, 4'b0001, 11'd1, 20'h18028, 16'h0010);
    tick();
    idle_in();
    chk("pidx_q2_lat1", avail_desc_o, 64'h0);
    tick();
    chk("pidx_q2_lat2", avail_desc_o, 64'h0000_0010_0000_0000);

    // consume: too many, exact, and zero
    cons_valid = 1'b1; cons_qid = 2'd2; cons_cnt = 16'd17;
    tick();
    chk("cons17_ready", 64'(cons_ready), 64'h0);
    cons_cnt = 16'd16;
    tick();
    chk("cons16_avail", avail_desc_o, 64'h0);
    cons_qid = 2'd1; cons_cnt = 16'd0;
    tick();
    idle_in();

    // wrap around the ring on q0
    set_beat(1'b1, 1'b1, 1'b1, 4'b0001, 11'd1, reg_addr(0, 0), 16'd1020);
    tick(); idle_in(); tick();
    cons_valid = 1'b1; cons_qid = 2'd0; cons_cnt = 16'd1020;
    tick(); idle_in();
    set_beat(1'b1, 1'b1, 1'b1, 4'b0001, 11'd1, reg_addr(0, 0), 16'd4);
    tick(); idle_in(); tick();
    chk("wrap_avail", 64'(avail_desc_o[15:0]), 64'd8);
    chk("wrap_noerr", 64'(err_o[0]), 64'd0);
    set_beat(1'b1, 1'b1, 1'b1, 4'b0001, 11'd1, reg_addr(0, 0), 16'd2);
    tick(); idle_in(); tick();
    chk("wrap_err", 64'(err_o[0]), 64'd1);

    // filtered beats
    set_beat(1'b1, 1'b1, 1'b0, 4'b0010, 11'd4, 20'h00100, 16'd0);
    tick();
    set_beat(1'b1, 1'b1, 1'b1, 4'b0001, 11'd1, reg_addr(0, 1), 16'd50);
    tick();
    set_beat(1'b1, 1'b1, 1'b1, 4'b0000, 11'd1, reg_addr(0, 1), 16'd9);
    tick();
    set_beat(1'b1, 1'b1, 1'b1, 4'b0001, 11'd1, 20'h18048, 16'd9);
    tick();
    set_beat(1'b1, 1'b0, 1'b1, 4'b0001, 11'd1, reg_addr(0, 1), 16'd9);
    tick();
    set_beat(1'b1, 1'b1, 1'b1, 4'b0001, 11'd0, reg_addr(0, 1), 16'd9);
    tick(); idle_in(); tick(); tick();
    chk("filter_avail", avail_desc_o, 64'h0000_0000_0000_0006);

    // fill the q1 completion ring, then free entries by a CIDX write
    cmpt_valid = 1'b1; cmpt_qid = 2'd1;
    repeat (1023) tick();
    chk("cmpt_full_space", 64'(cmpt_space_o[31:16]), 64'd0);
    chk("cmpt_full_ready", 64'(cmpt_ready), 64'd0);
    idle_in();
    set_beat(1'b1, 1'b1, 1'b1, 4'b0001, 11'd1, 20'h1801C, 16'd5);
    tick(); idle_in(); tick();
    chk("cmpt_cidx_space", 64'(cmpt_space_o[31:16]), 64'd5);

    // q3: write coinciding with consume, then reset mid-packet
    set_beat(1'b1, 1'b1, 1'b1, 4'b0001, 11'd1, reg_addr(0, 3), 16'd10);
    tick(); idle_in(); tick();
    set_beat(1'b1, 1'b1, 1'b1, 4'b0001, 11'd1, reg_addr(0, 3), 16'd20);
    cons_valid = 1'b1; cons_qid = 2'd3; cons_cnt = 16'd3;
    tick(); idle_in(); tick();
    chk("q3_avail17", 64'(avail_desc_o[63:48]), 64'd17);
    set_beat(1'b1, 1'b1, 1'b1, 4'b0001, 11'd1, reg_addr(0, 3), 16'd30);
    tick(); idle_in();
    cons_valid = 1'b1; cons_qid = 2'd3; cons_cnt = 16'd5;
    tick(); idle_in();
    chk("q3_same_cycle", 64'(avail_desc_o[63:48]), 64'd22);
    set_beat(1'b1, 1'b1, 1'b0, 4'b0001, 11'd1, reg_addr(0, 3), 16'd100);
    tick(); idle_in();
    #2 user_resetn_ip = 1'b0;
    #1;
    chk("arst_avail", avail_desc_o, 64'h0);
    chk("arst_space", cmpt_space_o, 64'h03FF_03FF_03FF_03FF);
    chk("arst_err", 64'(err_o), 64'h0);
    cons_valid = 1'b1; cons_qid = 2'd3; cons_cnt = 16'd0;
    #1 chk("arst_cons0", 64'(cons_ready), 64'd1);
    cons_cnt = 16'd1;
    #1 chk("arst_cons1", 64'(cons_ready), 64'd0);
    cmpt_valid = 1'b1; cmpt_qid = 2'd2;
    #1 chk("arst_cmpt", 64'(cmpt_ready), 64'd1);
    idle_in();
    model_reset();
    @(negedge user_clk_ip);
    @(negedge user_clk_ip);
    user_resetn_ip = 1'b1;
    set_beat(1'b1, 1'b1, 1'b1, 4'b0001, 11'd1, reg_addr(0, 3), 16'd7);
    tick(); idle_in(); tick();
    chk("post_rst_sop", avail_desc_o, 64'h0007_0000_0000_0000);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      q = int'($urandom % 5);
      kind = int'($urandom % 3);
      set_beat($urandom % 4 != 0, $urandom % 4 != 0, $urandom % 3 != 0,
               ($urandom % 5 == 0) ? 4'($urandom) : 4'b0001,
               ($urandom % 8 == 0) ? 11'd0 : 11'($urandom_range(1, 2047)),
               (kind == 2) ? 20'($urandom) : reg_addr(kind, q),
               ($urandom % 3 == 0) ? 16'($urandom) : 16'($urandom_range(0, 1023)));
      cons_valid = 1'($urandom % 2);
      cons_qid   = 2'($urandom);
      cons_cnt   = 16'($urandom_range(0, 32'(m_avail(int'(cons_qid)) + 2)));
      cmpt_valid = 1'($urandom % 2);
      cmpt_qid   = 2'($urandom);
      tick();
    end
    idle_in();
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
